// File: rtl/motoro3_step_sequencer.sv
// Six-step commutation sequencer for the 3-phase drive.
// Holds the rotor at step 0 for a fixed alignment time. It then runs open
// loop, shortening the step period by a fixed amount once per electrical
// cycle until the target period is reached. Every output is registered.
module motoro3_step_sequencer #(
  parameter logic [24:0] ALIGN_PERIOD  = 25'd5_000_000,
  parameter logic [24:0] START_PERIOD  = 25'd500_000,
  parameter logic [24:0] TARGET_PERIOD = 25'd20_000,
  parameter logic [24:0] RAMP_DEC      = 25'd10_000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        run,
  input  logic        dir,
  input  logic        fault,
  output logic        aE,
  output logic        bE,
  output logic        cE,
  output logic        aH,
  output logic        bH,
  output logic        cH,
  output logic [24:0] m3cnt,
  output logic        m3cntLast1,
  output logic [2:0]  step,
  output logic        faultLatched,
  output logic        cycleDone
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } stateT;

  stateT       state;
  logic [24:0] period;
  logic [5:0]  phaseOut;      // {aE,bE,cE,aH,bH,cH}, registered
  logic [2:0]  stepNext;
  logic        cycleWrap;
  logic [24:0] periodRamped;

  // Step table: enables in the upper three bits, high-side selects below.
  function automatic logic [5:0] phaseDrive(input logic [2:0] s);
    logic [5:0] drv;
    case (s)
      3'd0:    drv = {3'b110, 3'b100};
      3'd1:    drv = {3'b101, 3'b100};
      3'd2:    drv = {3'b011, 3'b010};
      3'd3:    drv = {3'b110, 3'b010};
      3'd4:    drv = {3'b101, 3'b001};
      3'd5:    drv = {3'b011, 3'b001};
      default: drv = 6'b000_000;
    endcase
    return drv;
  endfunction

  // Period after one ramp decrement. The subtraction is one bit wider so an
  // underflow shows up in the top bit, and the result clamps at the target.
  function automatic logic [24:0] rampPeriod(input logic [24:0] p);
    logic [25:0] diff;
    logic [24:0] res;
    diff = {1'b0, p} - {1'b0, RAMP_DEC};
    if (diff[25] || (diff[24:0] < TARGET_PERIOD)) begin
      res = TARGET_PERIOD;
    end else begin
      res = diff[24:0];
    end
    return res;
  endfunction

  assign {aE, bE, cE, aH, bH, cH} = phaseOut;

  // Next step and electrical-cycle wrap, evaluated against the sampled dir.
  always_comb begin
    stepNext     = 3'd0;
    cycleWrap    = 1'b0;
    periodRamped = rampPeriod(period);
    if (dir) begin
      if (step == 3'd0) begin
        stepNext  = 3'd5;
        cycleWrap = 1'b1;
      end else begin
        stepNext  = step - 3'd1;
        cycleWrap = 1'b0;
      end
    end else begin
      if (step >= 3'd5) begin
        stepNext  = 3'd0;
        cycleWrap = 1'b1;
      end else begin
        stepNext  = step + 3'd1;
        cycleWrap = 1'b0;
      end
    end
  end

  // Sequencer state machine. Outputs are registered.
  // Event priority is fault, then run low, then the step boundary.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state        <= IDLE;
      period       <= START_PERIOD;
      phaseOut     <= 6'd0;
      m3cnt        <= 25'd0;
      m3cntLast1   <= 1'b0;
      step         <= 3'd0;
      faultLatched <= 1'b0;
      cycleDone    <= 1'b0;
    end else begin
      cycleDone <= 1'b0;
      if (fault) begin
        state        <= IDLE;
        faultLatched <= 1'b1;
        phaseOut     <= 6'd0;
        m3cnt        <= 25'd0;
        m3cntLast1   <= 1'b0;
        step         <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            phaseOut   <= 6'd0;
            m3cnt      <= 25'd0;
            m3cntLast1 <= 1'b0;
            step       <= 3'd0;
            if (faultLatched) begin
              if (!run) begin
                faultLatched <= 1'b0;
              end
            end else if (run) begin
              state      <= ALIGN;
              period     <= START_PERIOD;
              m3cnt      <= ALIGN_PERIOD - 25'd1;
              m3cntLast1 <= (ALIGN_PERIOD == 25'd1);
              phaseOut   <= phaseDrive(3'd0);
            end
          end
          ALIGN: begin
            if (!run) begin
              state      <= IDLE;
              phaseOut   <= 6'd0;
              m3cnt      <= 25'd0;
              m3cntLast1 <= 1'b0;
              step       <= 3'd0;
            end else if (m3cnt == 25'd0) begin
              state      <= RUN;
              step       <= 3'd0;
              phaseOut   <= phaseDrive(3'd0);
              m3cnt      <= period - 25'd1;
              m3cntLast1 <= (period == 25'd1);
            end else begin
              m3cnt      <= m3cnt - 25'd1;
              m3cntLast1 <= (m3cnt == 25'd1);
            end
          end
          RUN: begin
            if (!run) begin
              state      <= IDLE;
              phaseOut   <= 6'd0;
              m3cnt      <= 25'd0;
              m3cntLast1 <= 1'b0;
              step       <= 3'd0;
            end else if (m3cnt == 25'd0) begin
              step     <= stepNext;
              phaseOut <= phaseDrive(stepNext);
              if (cycleWrap) begin
                // The ramped period governs the step that starts on this wrap.
                cycleDone  <= 1'b1;
                period     <= periodRamped;
                m3cnt      <= periodRamped - 25'd1;
                m3cntLast1 <= (periodRamped == 25'd1);
              end else begin
                m3cnt      <= period - 25'd1;
                m3cntLast1 <= (period == 25'd1);
              end
            end else begin
              m3cnt      <= m3cnt - 25'd1;
              m3cntLast1 <= (m3cnt == 25'd1);
            end
          end
          default: begin
            state      <= IDLE;
            phaseOut   <= 6'd0;
            m3cnt      <= 25'd0;
            m3cntLast1 <= 1'b0;
            step       <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed bench for motoro3_step_sequencer using small timing parameters.
module tb_motoro3_step_sequencer;

  logic        clk;
  logic        nRst;
  logic        run;
  logic        dir;
  logic        fault;
  logic        aE, bE, cE, aH, bH, cH;
  logic [24:0] m3cnt;
  logic        m3cntLast1;
  logic [2:0]  step;
  logic        faultLatched;
  logic        cycleDone;

  int nChecks = 0;
  int nErrors = 0;

  logic [2:0] expE [6];
  logic [2:0] expH [6];
  int         lens [4];

  motoro3_step_sequencer #(
    .ALIGN_PERIOD (25'd10),
    .START_PERIOD (25'd8),
    .TARGET_PERIOD(25'd4),
    .RAMP_DEC     (25'd2)
  ) dut (
    .clk         (clk),
    .nRst        (nRst),
    .run         (run),
    .dir         (dir),
    .fault       (fault),
    .aE          (aE),
    .bE          (bE),
    .cE          (cE),
    .aH          (aH),
    .bH          (bH),
    .cH          (cH),
    .m3cnt       (m3cnt),
    .m3cntLast1  (m3cntLast1),
    .step        (step),
    .faultLatched(faultLatched),
    .cycleDone   (cycleDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Everything the bench expects to be zero while stopped or in reset.
  task automatic chkIdle(input string tag, input logic expLatched);
    chk({tag, "_E"}, {29'd0, aE, bE, cE}, 32'd0);
    chk({tag, "_H"}, {29'd0, aH, bH, cH}, 32'd0);
    chk({tag, "_cnt"}, {7'd0, m3cnt}, 32'd0);
    chk({tag, "_last"}, {31'd0, m3cntLast1}, 32'd0);
    chk({tag, "_step"}, {29'd0, step}, 32'd0);
    chk({tag, "_cd"}, {31'd0, cycleDone}, 32'd0);
    chk({tag, "_flt"}, {31'd0, faultLatched}, {31'd0, expLatched});
  endtask

  task automatic runAlign();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("align_E", {29'd0, aE, bE, cE}, 32'b110);
      chk("align_H", {29'd0, aH, bH, cH}, 32'b100);
      chk("align_step", {29'd0, step}, 32'd0);
      chk("align_cnt", {7'd0, m3cnt}, 32'(9 - k));
      chk("align_last", {31'd0, m3cntLast1}, (k == 9) ? 32'd1 : 32'd0);
      chk("align_cd", {31'd0, cycleDone}, 32'd0);
    end
  endtask

  // One full RUN step of len clks; dir is inverted after the check at k == flipAt.
  task automatic runStep(input int s, input int len, input bit cd, input int flipAt);
    for (int k = 0; k < len; k++) begin
      tick();
      chk("run_step", {29'd0, step}, 32'(s));
      chk("run_E", {29'd0, aE, bE, cE}, {29'd0, expE[s]});
      chk("run_H", {29'd0, aH, bH, cH}, {29'd0, expH[s]});
      chk("run_cnt", {7'd0, m3cnt}, 32'(len - 1 - k));
      chk("run_last", {31'd0, m3cntLast1}, (k == len - 1) ? 32'd1 : 32'd0);
      chk("run_cd", {31'd0, cycleDone}, (cd && k == 0) ? 32'd1 : 32'd0);
      if (k == flipAt) dir = ~dir;
    end
  endtask

  initial begin
    expE[0] = 3'b110; expH[0] = 3'b100;
    expE[1] = 3'b101; expH[1] = 3'b100;
    expE[2] = 3'b011; expH[2] = 3'b010;
    expE[3] = 3'b110; expH[3] = 3'b010;
    expE[4] = 3'b101; expH[4] = 3'b001;
    expE[5] = 3'b011; expH[5] = 3'b001;
    lens[0] = 8; lens[1] = 6; lens[2] = 4; lens[3] = 4;

    // Reset held while the inputs toggle.
    nRst = 1'b1; run = 1'b0; dir = 1'b0; fault = 1'b0;
    #3 nRst = 1'b0;
    tick();
    run = 1'b1; fault = 1'b1;
    tick();
    dir = 1'b1; fault = 1'b0;
    tick();
    chkIdle("reset", 1'b0);
    run = 1'b0; dir = 1'b0;
    nRst = 1'b1;
    tick();
    chkIdle("idle", 1'b0);

    // Alignment, then four forward cycles ramping 8, 6, 4, 4.
    run = 1'b1;
    runAlign();
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < 6; s++) begin
        runStep(s, lens[c], (s == 0 && c > 0), -1);
      end
    end

    // Forward wrap at the saturated period; dir goes to 1 on the final clk.
    runStep(0, 4, 1'b1, 3);
    // Reverse: 0 -> 5 is a wrap, then 4, 3, 2.
    runStep(5, 4, 1'b1, -1);
    runStep(4, 4, 1'b0, -1);
    runStep(3, 4, 1'b0, -1);
    // dir returns to forward mid-step; the change shows only at the next boundary.
    runStep(2, 4, 1'b0, 1);
    runStep(3, 4, 1'b0, -1);
    runStep(4, 4, 1'b0, -1);
    runStep(5, 4, 1'b0, -1);
    runStep(0, 4, 1'b1, -1);

    // Stop mid-step at m3cnt == 3.
    tick();
    chk("stop_pre_step", {29'd0, step}, 32'd1);
    chk("stop_pre_cnt", {7'd0, m3cnt}, 32'd3);
    run = 1'b0;
    tick();
    chkIdle("stop", 1'b0);
    tick();
    chkIdle("stop_hold", 1'b0);

    // Restart: the period is back to its start value.
    run = 1'b1;
    runAlign();
    runStep(0, 8, 1'b0, -1);

    // Single-clk fault pulse during RUN.
    tick();
    chk("flt_pre_cnt", {7'd0, m3cnt}, 32'd7);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    chkIdle("fault", 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chkIdle("fault_hold", 1'b1);
    end
    run = 1'b0;
    tick();
    chkIdle("fault_clr", 1'b0);
    run = 1'b1;
    tick();
    chk("rearm_E", {29'd0, aE, bE, cE}, 32'b110);
    chk("rearm_cnt", {7'd0, m3cnt}, 32'd9);

    // Asynchronous reset in the middle of ALIGN, checked before the next edge.
    tick();
    #2 nRst = 1'b0;
    #1;
    chkIdle("async_rst", 1'b0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/motoro3_step_sequencer.md
# motoro3_step_sequencer

Six-step commutation sequencer for the 3-phase motor drive. It produces the per-phase enables `aE`/`bE`/`cE`, high-side selects, the step counter `m3cnt`, and the end-of-step strobe `m3cntLast1`. These feed the PWM generator directly downstream, which reloads its on/off timing on `m3cntLast1` or when all enables are low. Supported sequence: a fixed-time rotor alignment, then open-loop run with a linear soft-start ramp from a start period down to a target step period.

## Interface
- `ALIGN_PERIOD`, 25'd5_000_000, clk cycles the rotor is held at step 0 before running (0.5 s at 10 MHz)
- `START_PERIOD`, 25'd500_000, first run step length in clk cycles
- `TARGET_PERIOD`, 25'd20_000, final run step length; legal range 2 ≤ TARGET_PERIOD ≤ START_PERIOD
- `RAMP_DEC`, 25'd10_000, period decrement applied once per electrical cycle
- `clk`  input  1  system clock, 10 MHz
- `nRst`  input  1  asynchronous active-low reset
- `run`  input  1  level; 1 = spin, 0 = stop
- `dir`  input  1  0 = forward (step increments), 1 = reverse (step decrements)
- `fault`  input  1  level; forces stop while high
- `aE`, `bE`, `cE`  output  1 each  phase enable
- `aH`, `bH`, `cH`  output  1 each  high-side select; 1 = enabled phase is driven high, 0 = driven low
- `m3cnt`  output  25  current step down-counter
- `m3cntLast1`  output  1  high for the single clk where `m3cnt == 0` in ALIGN/RUN
- `step`  output  3  current commutation step, 0..5
- `faultLatched`  output  1  sticky fault flag
- `cycleDone`  output  1  one-clk pulse on each electrical-cycle wrap in RUN

## Operation
- States: IDLE, ALIGN, RUN. All outputs are registered on `posedge clk`.
- Reset value of every output is 0; the state resets to IDLE and the internal `period` register resets to START_PERIOD.
- **IDLE:**
  - Enables = 000, H = 000, `m3cnt` = 0, `m3cntLast1` = 0, `step` = 0.
  - If `run & ~fault & ~faultLatched`: go to ALIGN, load `m3cnt` = ALIGN_PERIOD-1, load `period` = START_PERIOD.
- **ALIGN:**
  - Step 0 is driven.
  - `m3cnt` decrements each clk.
  - When `m3cnt == 0`, the next clk enters RUN with `step` = 0 and `m3cnt` = `period`-1.
- **RUN:**
  - `m3cnt` decrements each clk.
  - When `m3cnt == 0`, the next clk advances `step` (+1 mod 6 forward, -1 mod 6 reverse) and reloads `m3cnt` = `period`-1.
  - `dir` is sampled only at that boundary.
- **Step table** (E = aE bE cE, H = aH bH cH):
  - step 0: E=110, H=100
  - step 1: E=101, H=100
  - step 2: E=011, H=010
  - step 3: E=110, H=010
  - step 4: E=101, H=001
  - step 5: E=011, H=001
- **Ramp:**
  - On the 5→0 wrap (forward) or 0→5 wrap (reverse), `cycleDone` pulses.
  - In the same clk, `period` = max(`period` - RAMP_DEC, TARGET_PERIOD).
  - Arithmetic is 26-bit to detect underflow; the result saturates at TARGET_PERIOD and never wraps.
  - The new period applies to the step that starts on that wrap.
- **Stop:**
  - `run` low in ALIGN/RUN → IDLE on the next clk, with all enables 0.
  - `m3cntLast1` is not pulsed on stop. The PWM stage resets itself on enables = 000.
- **Fault:**
  - `fault` high in any state → IDLE on the next clk and `faultLatched` = 1.
  - `faultLatched` clears only in IDLE while `run == 0` and `fault == 0`.
  - While latched, `run` is ignored.
- **Priority when events coincide:** fault > run low > step boundary.
- **Reset mid-operation:** `nRst` low asynchronously forces all outputs to 0 at once, regardless of state.

## Timing
- `run` rising edge (with fault clear) to the first enables = 110: 1 clk.
- ALIGN lasts exactly ALIGN_PERIOD clks.
- Each RUN step lasts exactly `period` clks, counting from the reload clk through the clk with `m3cnt == 0` inclusive.
- `m3cntLast1` is high exactly during the final clk of each ALIGN/RUN step. Step/enable outputs change on the following clk edge.
- `cycleDone` coincides with the clk in which step 0 (forward) or step 5 (reverse) begins.
- Stop/fault response: 1 clk from the sampled input to enables = 000.

## Test plan
- **Reset:** hold `nRst` = 0, toggle inputs → all outputs 0. Release → IDLE, enables 000.
- **Align then run:** ALIGN_PERIOD=10, START=8, TARGET=4, RAMP_DEC=2, `run`=1.
  - Required: 10 clks with E=110, then steps 0..5 each lasting 8 clks.
  - `m3cntLast1` high once per step, on `m3cnt == 0`.
- **Ramp saturation:** same parameters, run 4 electrical cycles → step lengths 8, 6, 4, 4 per cycle, with `cycleDone` pulsing at each wrap.
- **Reverse and direction change:** `dir`=1 → sequence 0,5,4,3,2,1. Toggle `dir` mid-step → the change takes effect only at the next `m3cnt == 0` boundary.
- **Stop mid-step:** drop `run` at `m3cnt` = 3 → next clk enables 000, `m3cnt` = 0, no `m3cntLast1` pulse. Re-raise `run` → ALIGN restarts with period = START.
- **Fault latch:** pulse `fault` for 1 clk during RUN → IDLE, `faultLatched` = 1.
  - `run` held 1 → stays IDLE.
  - `run` = 0 → `faultLatched` clears.
  - `run` = 1 again → ALIGN.
